// File: rtl/mult8_seq_ctrl_pkg.sv
// Shared definitions for the 8x8 sequential multiplier controller.
// Includes the state encoding, the nibble width and the shift table for each step.
package mult8_seq_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] SH0 = 4'd0;
  localparam logic [3:0] SH1 = 4'd4;
  localparam logic [3:0] SH2 = 4'd4;
  localparam logic [3:0] SH3 = 4'd8;

  function automatic logic [3:0] step_shift(input logic [1:0] step);
    case (step)
      2'd0:    return SH0;
      2'd1:    return SH1;
      2'd2:    return SH2;
      default: return SH3;
    endcase
  endfunction

endpackage

// File: rtl/mult8_seq_ctrl_array_mult4.sv
// Combinational 4x4 unsigned array multiplier.
// Built as rows of ripple full adders, one row per multiplier bit.
module array_mult4
  import mult8_seq_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0]   m,
  input  logic [NIB_W-1:0]   q,
  output logic [2*NIB_W-1:0] p
);

  logic [2*NIB_W-1:0] sum;
  logic               carry;
  logic               pp_bit;
  logic               s_bit;

  always_comb begin
    sum    = '0;
    carry  = 1'b0;
    pp_bit = 1'b0;
    s_bit  = 1'b0;
    for (int j = 0; j < NIB_W; j++) begin
      sum[j] = m[j] & q[0];
    end
    // Each row adds (m & q[i]) << i into the running sum.
    // The bit above the row is still zero at that point, so the row carry-out lands there.
    for (int i = 1; i < NIB_W; i++) begin
      carry = 1'b0;
      for (int j = 0; j < NIB_W; j++) begin
        pp_bit     = m[j] & q[i];
        s_bit      = sum[i+j] ^ pp_bit ^ carry;
        carry      = (sum[i+j] & pp_bit) | (carry & (sum[i+j] ^ pp_bit));
        sum[i+j]   = s_bit;
      end
      sum[i+NIB_W] = carry;
    end
    p = sum;
  end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Builds an 8x8 unsigned multiply from one shared 4x4 array multiplier over four steps.
// Operands arrive on a valid/ready handshake, and the product leaves on a second one.
module mult8_seq_ctrl
  import mult8_seq_ctrl_pkg::*;
#(
  parameter int ZERO_SKIP = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      product,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_e             state_q, state_d;
  logic [1:0]         step_q, step_d;
  logic [7:0]         a_r_q, a_r_d;
  logic [7:0]         b_r_q, b_r_d;
  logic [15:0]        acc_q, acc_d;
  logic [15:0]        product_q, product_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;

  logic [NIB_W-1:0]   core_m;
  logic [NIB_W-1:0]   core_q;
  logic [2*NIB_W-1:0] core_p;
  logic [15:0]        pp_ext;

  // step[0] selects the high nibble of a, and step[1] selects the high nibble of b.
  assign core_m = step_q[0] ? a_r_q[7:4] : a_r_q[3:0];
  assign core_q = step_q[1] ? b_r_q[7:4] : b_r_q[3:0];
  assign pp_ext = 16'(core_p) << step_shift(step_q);

  array_mult4 u_core (
    .m (core_m),
    .q (core_q),
    .p (core_p)
  );

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    a_r_d      = a_r_q;
    b_r_d      = b_r_q;
    acc_d      = acc_q;
    product_d  = product_q;
    op_count_d = op_count_q;
    case (state_q)
      IDLE: begin
        if (!abort && in_valid) begin
          a_r_d  = a;
          b_r_d  = b;
          acc_d  = '0;
          step_d = 2'd0;
          if ((ZERO_SKIP != 0) && ((a == 8'd0) || (b == 8'd0))) begin
            state_d   = DONE;
            product_d = '0;
          end else begin
            state_d = MUL;
          end
        end
      end
      MUL: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d  = acc_q + pp_ext;
          step_d = step_q + 2'd1;
          if (step_q == 2'd3) begin
            state_d   = DONE;
            product_d = acc_d;
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          state_d    = IDLE;
          op_count_d = op_count_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      step_q     <= '0;
      a_r_q      <= '0;
      b_r_q      <= '0;
      acc_q      <= '0;
      product_q  <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      a_r_q      <= a_r_d;
      b_r_q      <= b_r_d;
      acc_q      <= acc_d;
      product_q  <= product_d;
      op_count_q <= op_count_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Directed bench for mult8_seq_ctrl: handshakes, step accumulation, zero skip, backpressure, abort and async reset.
module tb_mult8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_valid_z;
  logic [7:0]  a, b;
  logic        abort, out_ready;
  logic        in_ready, out_valid, busy;
  logic [15:0] product;
  logic [7:0]  op_count;
  logic        z_in_ready, z_out_valid, z_busy;
  logic [15:0] z_product;
  logic [7:0]  z_op_count;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  mult8_seq_ctrl #(.ZERO_SKIP(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy), .op_count(op_count)
  );

  mult8_seq_ctrl #(.ZERO_SKIP(0), .CNT_W(8)) dut_nz (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_z), .in_ready(z_in_ready),
    .a(a), .b(b), .abort(abort), .out_valid(z_out_valid), .out_ready(out_ready),
    .product(z_product), .busy(z_busy), .op_count(z_op_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] av, input logic [7:0] bv);
    a = av; b = bv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  localparam logic [15:0] FF_STEPS [4] = '{16'h00E1, 16'h0EF1, 16'h1D01, 16'hFE01};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_valid_z = 1'b0; a = '0; b = '0;
    abort = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_product", 32'(product), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_op_count", 32'(op_count), 0);
    #10 rst_n = 1'b1;
    tick();

    // Basic multiply with immediate consumption
    out_ready = 1'b1;
    accept(8'h12, 8'h34);
    chk("t1_busy", 32'(busy), 1);
    wait_valid(lat);
    chk("t1_lat", 32'(lat), 4);
    chk("t1_product", 32'(product), 32'h03A8);
    tick();
    chk("t1_out_valid_drop", 32'(out_valid), 0);
    chk("t1_op_count", 32'(op_count), 1);

    // Per-step accumulator for the largest operands
    accept(8'hFF, 8'hFF);
    chk("t2_acc_init", 32'(dut.acc_q), 0);
    for (int s = 0; s < 4; s++) begin
      tick();
      chk($sformatf("t2_acc_step%0d", s), 32'(dut.acc_q), 32'(FF_STEPS[s]));
    end
    chk("t2_out_valid", 32'(out_valid), 1);
    chk("t2_product", 32'(product), 32'hFE01);
    tick();
    chk("t2_op_count", 32'(op_count), 2);

    // Zero operand: skip on dut, full four steps on dut_nz
    a = 8'h00; b = 8'h55; in_valid = 1'b1; in_valid_z = 1'b1;
    tick();
    in_valid = 1'b0; in_valid_z = 1'b0;
    chk("t3_zs_out_valid", 32'(out_valid), 1);
    chk("t3_zs_product", 32'(product), 0);
    chk("t3_nz_out_valid", 32'(z_out_valid), 0);
    lat = 0;
    while (!z_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("t3_nz_lat", 32'(lat), 4);
    chk("t3_nz_product", 32'(z_product), 0);
    chk("t3_zs_op_count", 32'(op_count), 3);
    tick();
    chk("t3_nz_op_count", 32'(z_op_count), 1);

    // Backpressure with an in_valid pulse ignored during DONE
    out_ready = 1'b0;
    accept(8'h0F, 8'h11);
    wait_valid(lat);
    chk("t4_lat", 32'(lat), 4);
    for (int c = 0; c < 3; c++) begin
      chk("t4_product_hold", 32'(product), 32'h00FF);
      chk("t4_in_ready", 32'(in_ready), 0);
      chk("t4_busy", 32'(busy), 1);
      chk("t4_out_valid", 32'(out_valid), 1);
      a = 8'h77; b = 8'h77; in_valid = (c == 1);
      tick();
      in_valid = 1'b0;
    end
    chk("t4_product_hold_end", 32'(product), 32'h00FF);
    chk("t4_op_count_held", 32'(op_count), 3);
    out_ready = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t4_out_valid_drop", 32'(out_valid), 0);
    chk("t4_no_accept_on_consume", 32'(busy), 0);
    chk("t4_op_count", 32'(op_count), 4);
    chk("t4_product_after", 32'(product), 32'h00FF);

    // Abort at step2, then abort in IDLE wins over in_valid
    accept(8'hAB, 8'hCD);
    tick(); tick();
    chk("t5_step2", 32'(dut.step_q), 2);
    abort = 1'b1;
    tick();
    chk("t5_abort_busy", 32'(busy), 0);
    chk("t5_abort_out_valid", 32'(out_valid), 0);
    chk("t5_abort_op_count", 32'(op_count), 4);
    a = 8'h03; b = 8'h05; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    chk("t5_idle_abort_blocks", 32'(busy), 0);
    out_ready = 1'b0;
    accept(8'h03, 8'h05);
    wait_valid(lat);
    chk("t5_product", 32'(product), 32'h000F);
    abort = 1'b1; out_ready = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_done_abort_valid", 32'(out_valid), 0);
    chk("t5_done_abort_count", 32'(op_count), 4);

    // Asynchronous reset mid-MUL
    accept(8'h10, 8'h10);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_in_ready", 32'(in_ready), 1);
    chk("t6_rst_out_valid", 32'(out_valid), 0);
    chk("t6_rst_product", 32'(product), 0);
    chk("t6_rst_op_count", 32'(op_count), 0);
    #2 rst_n = 1'b1;
    tick();
    accept(8'h10, 8'h10);
    wait_valid(lat);
    chk("t6_lat", 32'(lat), 4);
    chk("t6_product", 32'(product), 32'h0100);
    tick();
    chk("t6_op_count", 32'(op_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
